// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Access size in bytes; funct3[1:0]==3 never reaches memory because it is illegal.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic wr, input logic [2:0] funct3);
    if (wr) return funct3 inside {F3_SB, F3_SH, F3_SW};
    else    return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: 8-bit lane mask, 64-bit shifted store data,
// and load assembly from two words with sign/zero extension.
module lsu_align (
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [5:0]  sh_bits;
  logic [63:0] rd_sh;

  assign sh_bits  = {off, 3'b000};
  assign wdata_sh = {32'd0, wdata} << sh_bits;
  assign rd_sh    = {rd_hi, rd_lo} >> sh_bits;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    mask  = 8'h0F;
    rdata = rd_sh[31:0];
    case (size)
      3'd1: begin
        mask  = 8'h01;
        rdata = sign ? {{24{rd_sh[7]}}, rd_sh[7:0]} : {24'd0, rd_sh[7:0]};
      end
      3'd2: begin
        mask  = 8'h03;
        rdata = sign ? {{16{rd_sh[15]}}, rd_sh[15:0]} : {16'd0, rd_sh[15:0]};
      end
      default: ;
    endcase
    mask = mask << off;
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-indexed, byte-enabled d_mem.
// Define LSU_MISALIGNED_EN to split word-crossing accesses; otherwise misaligned requests fault.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_WORDS);

  state_t      state_q;
  logic        accept, fault, crosses, out_of_range, split_go, in_split;
  logic [29:0] word_idx, word_nxt;
  logic [1:0]  off, asm_off;
  logic [2:0]  size_n, asm_size;
  logic        asm_sign;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [31:0] asm_lo, asm_hi, asm_rdata;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[31:2];
  assign word_nxt  = word_idx + 30'd1;
  assign off       = req_addr[1:0];
  assign size_n    = size_bytes(req_funct3);
  assign crosses   = |mask8[7:4];
  // The wrapped w+1 is compared too, so a crossing at the top of the map still faults.
  assign out_of_range = ({2'b00, word_idx} >= MEM_WORDS) ||
                        (crosses && ({2'b00, word_nxt} >= MEM_WORDS));

`ifdef LSU_MISALIGNED_EN
  state_t      state_d;
  logic [29:0] split_word;
  logic [3:0]  split_be;
  logic [31:0] split_wdata, hold_rd;
  logic [1:0]  split_off;
  logic [2:0]  split_size;
  logic        split_sign, split_wr;

  assign fault    = !funct3_legal(req_wr, req_funct3) || out_of_range;
  assign split_go = accept && !fault && crosses;
  assign in_split = (state_q == ST_SPLIT);
  assign asm_off  = in_split ? split_off  : off;
  assign asm_size = in_split ? split_size : size_n;
  assign asm_sign = in_split ? split_sign : !req_funct3[2];
  assign asm_lo   = in_split ? hold_rd    : mem_rd_data;
  assign asm_hi   = in_split ? mem_rd_data : 32'd0;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (split_go) state_d = ST_SPLIT;
      ST_SPLIT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: the hold registers are plain flops, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_word  <= '0;
      split_be    <= '0;
      split_wdata <= '0;
      split_off   <= '0;
      split_size  <= '0;
      split_sign  <= 1'b0;
      split_wr    <= 1'b0;
      hold_rd     <= '0;
    end else if (split_go) begin
      split_word  <= word_nxt;
      split_be    <= mask8[7:4];
      split_wdata <= wdata64[63:32];
      split_off   <= off;
      split_size  <= size_n;
      split_sign  <= !req_funct3[2];
      split_wr    <= req_wr;
      hold_rd     <= mem_rd_data;
    end
  end
`else
  logic misaligned;
  logic unused_split;

  assign state_q      = ST_IDLE;
  assign misaligned   = |(off & (size_n[1:0] - 2'd1));
  assign fault        = !funct3_legal(req_wr, req_funct3) || out_of_range || misaligned;
  assign split_go     = 1'b0;
  assign in_split     = 1'b0;
  assign asm_off      = off;
  assign asm_size     = size_n;
  assign asm_sign     = !req_funct3[2];
  assign asm_lo       = mem_rd_data;
  assign asm_hi       = 32'd0;
  assign unused_split = ^wdata64[63:32];
`endif

  lsu_align u_align (
    .off      (asm_off),
    .size     (asm_size),
    .sign     (asm_sign),
    .wdata    (req_wdata),
    .rd_lo    (asm_lo),
    .rd_hi    (asm_hi),
    .mask     (mask8),
    .wdata_sh (wdata64),
    .rdata    (asm_rdata)
  );

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_byte_en = '0;
    mem_wr_data = '0;
    if (!rst) begin
      if (accept && !fault) begin
        mem_addr    = {2'b00, word_idx};
        mem_byte_en = mask8[3:0];
        mem_wr_data = wdata64[31:0];
        mem_wr_en   = req_wr;
      end
`ifdef LSU_MISALIGNED_EN
      else if (in_split) begin
        mem_addr    = {2'b00, split_word};
        mem_byte_en = split_be;
        mem_wr_data = split_wdata;
        mem_wr_en   = split_wr;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      if (accept && fault) begin
        rsp_valid <= 1'b1;
        rsp_fault <= 1'b1;
      end else if (accept && !split_go) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= req_wr ? 32'd0 : asm_rdata;
      end
`ifdef LSU_MISALIGNED_EN
      else if (in_split) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= split_wr ? 32'd0 : asm_rdata;
      end
`endif
    end
  end

endmodule
